pushbutton_array: RTL and testbench

- Parametrised N-channel pushbutton front end for active-low board buttons.
- Per channel: 2-FF synchroniser, counter-based debounce and debounced level.
- Per channel event outputs: press pulse, release pulse, long-press pulse and a clearable toggle state.
- Sits between board pins and control FSMs; replaces per-button ad-hoc edge/toggle logic.

---
 rtl/pushbutton_pkg.sv | 12 +
 rtl/pushbutton_array_if.sv | 22 ++
 rtl/pushbutton_chan.sv | 96 +++++++++
 rtl/pushbutton_array.sv | 31 +++
 tb/tb_pushbutton_array.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pushbutton_pkg.sv
// Shared constants and counter sizing for the pushbutton front end.
package pushbutton_pkg;

    localparam int PB_DEBOUNCE_CYC_DEF = 16;
    localparam int PB_LONG_CYC_DEF     = 1000;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pushbutton_array_if.sv
// Button pins in, debounced levels and events out, one bit per channel.
interface pushbutton_array_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] pushn;
    logic [N_BTN-1:0] toggle_clr;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] toggle;

    modport master (
        output pushn, toggle_clr,
        input  level, press, release_pulse, long_press, toggle
    );

    modport slave (
        input  pushn, toggle_clr,
        output level, press, release_pulse, long_press, toggle
    );
endinterface

// File: rtl/pushbutton_chan.sv
// One button channel: synchroniser, debounce, press/release/long-press pulses
// and a clearable toggle. All outputs are registered.
module pushbutton_chan
    import pushbutton_pkg::*;
#(
    parameter int DEBOUNCE_CYC = PB_DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = PB_LONG_CYC_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic pushn,
    input  logic toggle_clr,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic toggle
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(LONG_CYC + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic          accept;
    logic          level_next;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    // NOTE: synchroniser flops reset to the released pin level (1), so a
    // button held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pushn;
            sync2 <= sync1;
        end
    end

    assign s          = ~sync2;
    assign accept     = (s != level) && (dcnt == D_LAST);
    assign level_next = accept ? s : level;

    // NOTE: non-blocking assignments let every register here sample the old
    // level in the same edge, which is what makes press/release edge pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt          <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            if ((s == level) || accept) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            level         <= level_next;
            press         <= level_next & ~level;
            release_pulse <= ~level_next & level;
        end
    end

    // Hold counter saturates, so long_press fires only on its first arrival.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            if (!level) begin
                hcnt <= '0;
            end else if (hcnt != H_MAX) begin
                hcnt <= hcnt + HW'(1);
            end
            long_press <= level && (hcnt == H_PRE);
        end
    end

    // Clear takes priority over a coincident press pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            toggle <= 1'b0;
        end else if (toggle_clr) begin
            toggle <= 1'b0;
        end else if (press) begin
            toggle <= ~toggle;
        end
    end

endmodule

// File: rtl/pushbutton_array.sv
// N_BTN independent pushbutton channels behind a single bus interface.
module pushbutton_array
    import pushbutton_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = PB_DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = PB_LONG_CYC_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    pushbutton_array_if.slave  bus
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        pushbutton_chan #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_chan (
            .clk           (clk),
            .resetn        (resetn),
            .pushn         (bus.pushn[i]),
            .toggle_clr    (bus.toggle_clr[i]),
            .level         (bus.level[i]),
            .press         (bus.press[i]),
            .release_pulse (bus.release_pulse[i]),
            .long_press    (bus.long_press[i]),
            .toggle        (bus.toggle[i])
        );
    end

endmodule

// File: tb/tb_pushbutton_array.sv
// Bench for pushbutton_array: directed scenarios plus random pin activity,
// all cycles compared against a sample-history reference model.
module tb_pushbutton_array;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int LONG  = 8;
    localparam int QN    = DEB + 2;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    pushbutton_array_if #(.N_BTN(N_BTN)) bus ();

    pushbutton_array #(
        .N_BTN        (N_BTN),
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LONG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last DEB synchronised samples
    // (pin history delayed two edges) all disagree with it.
    logic [N_BTN-1:0] hist_q[$];
    logic [N_BTN-1:0] exp_level, exp_press, exp_rel, exp_long, exp_tog;
    logic [N_BTN-1:0] old_level, old_press, new_level;
    bit               all_diff;
    int               k;
    int               rise_k[N_BTN];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k = 0;
            hist_q.delete();
            repeat (QN) hist_q.push_back('0);
            exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0; exp_tog = '0;
            for (int c = 0; c < N_BTN; c++) rise_k[c] = 0;
        end else begin
            k++;
            hist_q.push_back(~bus.pushn);
            void'(hist_q.pop_front());
            old_level = exp_level;
            old_press = exp_press;
            new_level = old_level;
            for (int c = 0; c < N_BTN; c++) begin
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (hist_q[i][c] == old_level[c]) all_diff = 1'b0;
                if (all_diff) new_level[c] = ~old_level[c];
                if (new_level[c] && !old_level[c]) rise_k[c] = k;
                exp_long[c] = old_level[c] && ((k - rise_k[c]) == LONG);
            end
            exp_level = new_level;
            exp_press = new_level & ~old_level;
            exp_rel   = ~new_level & old_level;
            exp_tog   = (exp_tog ^ old_press) & ~bus.toggle_clr;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks += 5;
            if (bus.level !== exp_level) begin
                failures++;
                $display("FAIL model_level t=%0t got=%b exp=%b", $time, bus.level, exp_level);
            end
            if (bus.press !== exp_press) begin
                failures++;
                $display("FAIL model_press t=%0t got=%b exp=%b", $time, bus.press, exp_press);
            end
            if (bus.release_pulse !== exp_rel) begin
                failures++;
                $display("FAIL model_release t=%0t got=%b exp=%b", $time, bus.release_pulse, exp_rel);
            end
            if (bus.long_press !== exp_long) begin
                failures++;
                $display("FAIL model_long t=%0t got=%b exp=%b", $time, bus.long_press, exp_long);
            end
            if (bus.toggle !== exp_tog) begin
                failures++;
                $display("FAIL model_toggle t=%0t got=%b exp=%b", $time, bus.toggle, exp_tog);
            end
        end
    end

    function automatic logic [5*N_BTN-1:0] all_outs();
        return {bus.level, bus.press, bus.release_pulse, bus.long_press, bus.toggle};
    endfunction

    // Waits for a pulse of the given kind on channel ch; n is the index of the
    // edge it followed (0 = first edge after the call), or -1 on timeout.
    task automatic wait_pulse(input int ch, input int kind, input int budget, output int n);
        logic [N_BTN-1:0] v;
        n = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            v = (kind == K_PRESS) ? bus.press : (kind == K_REL) ? bus.release_pulse : bus.long_press;
            if (v[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic settle(input int ch);
        int n;
        bus.pushn[ch] = 1'b1;
        if (bus.level[ch]) wait_pulse(ch, K_REL, 30, n);
        repeat (DEB + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.pushn      = '1;
        bus.toggle_clr = '0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        resetn = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (all_outs() !== '0) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d got=%h exp=0", i, all_outs());
            end
        end
    endtask

    task automatic test_clean_press();
        int n;
        bus.pushn[0] = 1'b0;
        wait_pulse(0, K_PRESS, 30, n);
        checks++;
        if (n !== DEB + 1) begin
            failures++;
            $display("FAIL press_latency got=%0d exp=%0d", n, DEB + 1);
        end
        checks++;
        if (bus.level !== 2'b01) begin
            failures++;
            $display("FAIL press_level got=%b exp=01", bus.level);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.press !== 2'b00) begin
            failures++;
            $display("FAIL press_width got=%b exp=00", bus.press);
        end
        bus.pushn[0] = 1'b1;
        wait_pulse(0, K_REL, 30, n);
        checks++;
        if (n !== DEB + 1) begin
            failures++;
            $display("FAIL release_latency got=%0d exp=%0d", n, DEB + 1);
        end
        checks++;
        if (bus.level !== 2'b00) begin
            failures++;
            $display("FAIL release_level got=%b exp=00", bus.level);
        end
        settle(0);
    endtask

    task automatic test_bounce();
        int presses = 0;
        int level_seen = 0;
        int pat_val[4] = '{0, 1, 0, 1};
        int pat_len[4] = '{3, 1, 3, 8};
        for (int p = 0; p < 4; p++) begin
            bus.pushn[0] = pat_val[p][0];
            repeat (pat_len[p]) begin
                @(posedge clk); #1;
                presses    += int'(bus.press[0]);
                level_seen += int'(bus.level[0]);
            end
        end
        checks++;
        if (presses != 0 || level_seen != 0) begin
            failures++;
            $display("FAIL bounce_reject got presses=%0d level_cycles=%0d exp=0", presses, level_seen);
        end
        bus.pushn[0] = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            presses += int'(bus.press[0]);
        end
        checks++;
        if (presses != 1 || bus.level[0] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_then_hold got presses=%0d level=%b exp 1 and 1", presses, bus.level[0]);
        end
        settle(0);
    endtask

    task automatic test_long();
        int n, cnt, at, hold_len;
        bus.pushn[1] = 1'b0;
        wait_pulse(1, K_PRESS, 30, n);
        cnt = 0;
        at  = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.long_press[1]) begin
                cnt++;
                if (at < 0) at = i;
            end
        end
        checks++;
        if (cnt != 1 || at != LONG) begin
            failures++;
            $display("FAIL long_once got count=%0d at=%0d exp count=1 at=%0d", cnt, at, LONG);
        end
        settle(1);
        bus.pushn[1] = 1'b0;
        wait_pulse(1, K_PRESS, 30, n);
        bus.pushn[1] = 1'b1;
        cnt      = 0;
        hold_len = 1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            cnt      += int'(bus.long_press[1]);
            hold_len += int'(bus.level[1]);
        end
        checks++;
        if (cnt != 0 || hold_len != 6) begin
            failures++;
            $display("FAIL long_short_hold got count=%0d hold=%0d exp count=0 hold=6", cnt, hold_len);
        end
        settle(1);
    endtask

    task automatic test_toggle();
        int n;
        bit seq[3] = '{1'b1, 1'b0, 1'b1};
        bus.toggle_clr[0] = 1'b1;
        @(posedge clk); #1;
        bus.toggle_clr[0] = 1'b0;
        checks++;
        if (bus.toggle[0] !== 1'b0) begin
            failures++;
            $display("FAIL toggle_clear got=%b exp=0", bus.toggle[0]);
        end
        for (int p = 0; p < 3; p++) begin
            bus.pushn[0] = 1'b0;
            wait_pulse(0, K_PRESS, 30, n);
            @(posedge clk); #1;
            checks++;
            if (bus.toggle[0] !== seq[p]) begin
                failures++;
                $display("FAIL toggle_seq%0d got=%b exp=%b", p, bus.toggle[0], seq[p]);
            end
            settle(0);
        end
        bus.pushn[0] = 1'b0;
        wait_pulse(0, K_PRESS, 30, n);
        bus.toggle_clr[0] = 1'b1;
        @(posedge clk); #1;
        bus.toggle_clr[0] = 1'b0;
        checks++;
        if (bus.toggle[0] !== 1'b0) begin
            failures++;
            $display("FAIL toggle_clr_wins got=%b exp=0", bus.toggle[0]);
        end
        settle(0);
    endtask

    task automatic test_reset_mid_hold();
        int n;
        bus.pushn[1] = 1'b0;
        wait_pulse(1, K_PRESS, 30, n);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_immediate got=%h exp=0", all_outs());
        end
        @(posedge clk); #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", all_outs());
        end
        resetn = 1'b1;
        wait_pulse(1, K_PRESS, 30, n);
        checks++;
        if (n !== DEB + 1) begin
            failures++;
            $display("FAIL reset_repress_latency got=%0d exp=%0d", n, DEB + 1);
        end
        wait_pulse(1, K_LONG, 30, n);
        checks++;
        if (n + 1 !== LONG) begin
            failures++;
            $display("FAIL reset_long_delay got=%0d exp=%0d", n + 1, LONG);
        end
        settle(1);
    endtask

    task automatic test_random();
        int hold_left[N_BTN];
        int presses = 0;
        int longs   = 0;
        for (int c = 0; c < N_BTN; c++) hold_left[c] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if (hold_left[c] == 0) begin
                    bus.pushn[c] = 1'($urandom_range(0, 1));
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                               : int'($urandom_range(4, 20));
                end
                hold_left[c]--;
            end
            bus.toggle_clr = ($urandom_range(0, 15) == 0) ? N_BTN'($urandom) : '0;
            if (cyc == 400) resetn = 1'b0;
            if (cyc == 402) resetn = 1'b1;
            @(posedge clk); #1;
            presses += $countones(bus.press);
            longs   += $countones(bus.long_press);
        end
        bus.toggle_clr = '0;
        checks++;
        if (presses == 0 || longs == 0) begin
            failures++;
            $display("FAIL random_activity got presses=%0d longs=%0d exp both nonzero", presses, longs);
        end
        settle(0);
        settle(1);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long();
        test_toggle();
        test_reset_mid_hold();
        test_random();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
